fp_add_normround: RTL and testbench
===================================

Name: fp_add_normround

Overview:
- Normalize-and-round back end of the single-precision adder used by the Nroot datapath.
- Sits directly downstream of the leading-one detector on the raw 25-bit mantissa sum, and consumes its shift count and zero flag.
- Two-stage valid/ready pipeline:
  - stage 1: normalize (1-bit right shift on carry-out, or left shift by the LZD count, with exponent adjust);
  - stage 2: round-to-nearest-even, overflow/underflow handling, and IEEE754 packing.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, stored fraction width; raw mantissa is FRAC_W+2 bits
- SH_W, 5, shift-count width from the LZD

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept this cycle
- in_sign  input  1  result sign, already resolved upstream
- in_exp  input  EXP_W  biased exponent of the aligned operands (1..254)
- in_mant  input  FRAC_W+2  raw sum; bit24 is carry-out, bit23 is the hidden position
- in_grs  input  3  guard, round, sticky bits below in_mant[0]
- in_nshift  input  SH_W  leading-zero count relative to bit23 (LZD output)
- in_zero  input  1  in_mant is all zero (LZD output)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  1+EXP_W+FRAC_W  packed IEEE754 result
- out_ovf  output  1  overflow flag
- out_unf  output  1  underflow (flush-to-zero) flag
- out_inx  output  1  inexact flag

Behaviour:
- Reset (synchronous on clk, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, all flags=0. Reset mid-stall discards all in-flight data.
- Handshake:
  - transfer occurs when valid&ready;
  - s2 advances when !s2_valid | out_ready;
  - s1 advances when !s1_valid | s2 advances;
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - Full throughput: one result per cycle.
  - Latency is 2 cycles from accept to out_valid.
  - out_* are held stable while out_valid & !out_ready.
  - Results leave in acceptance order.
- Stage 1 (normalize), working on the 28-bit vector V = {in_mant, in_grs}:
  - in_zero & in_grs==0: exact zero; output {in_sign, 0, 0}, no flags.
  - in_mant[24]=1: V >> 1, lost bit ORed into sticky; exp = in_exp+1.
  - else if in_exp > in_nshift: V << in_nshift, zero fill; exp = in_exp - in_nshift.
  - else: flush to zero; output {in_sign, 0, 0}, unf=1, inx=1.
  - Register per item: normalized frac[22:0], guard, round|sticky, exp (EXP_W+1 bits, unsigned), sign, and special-case flags.
- Stage 2 (round):
  - inc = g & (rs | frac[0]);
  - {c, frac'} = {0, 1, frac} + inc; if c=1 then exp+1 and frac'=0;
  - inx = g | rs.
  - If exp >= 255 (from stage 1 or rounding): output {sign, 8'hFF, 0}, ovf=1, inx=1.
  - Else: out_result = {sign, exp[7:0], frac'}.
- Zero/flush items skip rounding.
- in_exp=255 is never presented upstream; if it is, it is treated as overflow.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, SH_W, EXP_MAX (255), BIAS (127);
  - a packed result typedef {sign, exp, frac};
  - a flags struct {ovf, unf, inx}.
- One combinational sub-module, fp_round_rne (frac, g, rs, exp, sign -> packed result + flags), instantiated in stage 2.
- Pipeline control and normalization stay in the top.

Test Plan:
- 1.0+1.0: in_exp=127, in_mant=25'h1000000, grs=0, nshift=0 -> out_result 32'h40000000, flags 0, out_valid exactly 2 cycles after accept.
- Cancellation: in_exp=127, in_mant=25'h0000001, nshift=23 -> 32'h34000000, flags 0.
- RNE ties:
  - in_exp=127, in_mant=25'h0800001, grs=3'b100 -> 32'h3F800002, inx=1;
  - same with in_mant=25'h0800000 -> 32'h3F800000, inx=1.
- Rounding overflow: in_exp=254, in_mant=25'h0FFFFFF, grs=3'b110 -> 32'h7F800000, ovf=1, inx=1.
- Flush: in_exp=3, in_mant=25'h0000010, nshift=19, in_sign=1 -> 32'h80000000, unf=1, inx=1.
- Backpressure and reset:
  - 4 back-to-back items with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, out_result stable, all 4 emerge in order once out_ready=1;
  - rst pulse mid-stall -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision adder back end.
// Holds the field widths, exponent limits, and the packed result and
// exception-flag types passed between the normalize/round stages.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SH_W   = 5;
  localparam int BIAS   = 127;

  // Widened (EXP_W+1) so exponents carried out of normalization or
  // rounding can be compared against the overflow limit without wrapping.
  localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'(255);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_result_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and IEEE754 packing for a normalized value.
// Ports:
//   frac   : normalized fraction (hidden bit implied)
//   g, rs  : guard bit and round|sticky bit below frac[0]
//   exp    : biased exponent, one bit wider than the field
//   sign   : result sign
//   result : packed {sign, exp, frac} after rounding
//   flags  : ovf / unf / inx (unf is always 0 here)
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              g,
  input  logic              rs,
  input  logic [EXP_W:0]    exp,
  input  logic              sign,
  output fp_result_t        result,
  output fp_flags_t         flags
);

  logic                inc;
  logic [FRAC_W+1:0]   sum;
  logic [EXP_W:0]      exp_r;

  always_comb begin
    inc = g & (rs | frac[0]);
    // Hidden bit included so a carry out of the fraction shows up in the
    // top bit; in that case the low FRAC_W bits are already zero.
    sum   = {1'b0, 1'b1, frac} + {{(FRAC_W+1){1'b0}}, inc};
    exp_r = exp + {{EXP_W{1'b0}}, sum[FRAC_W+1]};

    result.sign = sign;
    flags.unf   = 1'b0;
    flags.ovf   = 1'b0;
    flags.inx   = g | rs;
    if (exp_r >= EXP_MAX) begin
      result.exp  = '1;
      result.frac = '0;
      flags.ovf   = 1'b1;
      flags.inx   = 1'b1;
    end else begin
      result.exp  = exp_r[EXP_W-1:0];
      result.frac = sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fp_add_normround.sv
// Normalize-and-round back end of the single-precision adder.
// Two-stage valid/ready pipeline: stage 1 normalizes the raw mantissa sum
// using the LZD shift count, stage 2 rounds (RNE), handles overflow and
// packs the IEEE754 result.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_sign, in_exp     : resolved sign, biased exponent of aligned operands
//   in_mant, in_grs     : raw 25-bit sum (bit24 carry, bit23 hidden) + g/r/s
//   in_nshift, in_zero  : LZD leading-zero count and all-zero flag
//   out_valid/out_ready : downstream handshake
//   out_result          : packed IEEE754 result
//   out_ovf/unf/inx     : overflow, flush-to-zero underflow, inexact
module fp_add_normround #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int SH_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+1:0]       in_mant,
  input  logic [2:0]              in_grs,
  input  logic [SH_W-1:0]         in_nshift,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inx
);
  import fp_pkg::*;

  localparam int VW = FRAC_W + 5;

  logic adv1, adv2;
  logic vld_p1, vld_p2;

  logic [VW-1:0]     v;
  logic [VW-3:0]     lsh;
  logic [FRAC_W-1:0] frac_n;
  logic              g_n, rs_n, zero_n, unf_n;
  logic [EXP_W:0]    exp_n;

  logic [FRAC_W-1:0] frac_p1;
  logic              g_p1, rs_p1, sign_p1, zero_p1, unf_p1;
  logic [EXP_W:0]    exp_p1;

  fp_result_t rnd_res, res_n, result_p2;
  fp_flags_t  rnd_flags, flags_n, flags_p2;

  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  // Stage 1: normalize V = {mant, grs}
  always_comb begin
    v      = {in_mant, in_grs};
    lsh    = v[VW-3:0] << in_nshift;
    frac_n = lsh[VW-3:3];
    g_n    = lsh[2];
    rs_n   = lsh[1] | lsh[0];
    exp_n  = {1'b0, in_exp} - {{(EXP_W+1-SH_W){1'b0}}, in_nshift};
    zero_n = 1'b0;
    unf_n  = 1'b0;
    if (in_zero && in_grs == 3'b000) begin
      zero_n = 1'b1;
    end else if (in_mant[FRAC_W+1]) begin
      // Carry-out: one-bit right shift, lost bits fold into round|sticky.
      frac_n = v[VW-2:4];
      g_n    = v[3];
      rs_n   = v[2] | v[1] | v[0];
      exp_n  = {1'b0, in_exp} + {{EXP_W{1'b0}}, 1'b1};
    end else if (in_exp <= {{(EXP_W-SH_W){1'b0}}, in_nshift}) begin
      // Shifting would drive the exponent to zero or below: flush.
      zero_n = 1'b1;
      unf_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      frac_p1 <= frac_n;
      g_p1    <= g_n;
      rs_p1   <= rs_n;
      exp_p1  <= exp_n;
      sign_p1 <= in_sign;
      zero_p1 <= zero_n;
      unf_p1  <= unf_n;
    end
  end

  // Stage 2: round and pack
  fp_round_rne u_round (
    .frac   (frac_p1),
    .g      (g_p1),
    .rs     (rs_p1),
    .exp    (exp_p1),
    .sign   (sign_p1),
    .result (rnd_res),
    .flags  (rnd_flags)
  );

  always_comb begin
    res_n   = rnd_res;
    flags_n = rnd_flags;
    if (zero_p1) begin
      res_n   = '{sign: sign_p1, exp: '0, frac: '0};
      flags_n = '{ovf: 1'b0, unf: unf_p1, inx: unf_p1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result_p2 <= res_n;
          flags_p2  <= flags_n;
        end
      end
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_ovf    = flags_p2.ovf;
  assign out_unf    = flags_p2.unf;
  assign out_inx    = flags_p2.inx;

endmodule

// File: tb/tb_fp_add_normround.sv
// Directed bench for fp_add_normround: a vector table of hand-computed
// results plus backpressure and mid-stall reset sequences.
module tb_fp_add_normround;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_zero;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic [4:0]  in_nshift;
  logic        out_valid, out_ready, out_ovf, out_unf, out_inx;
  logic [31:0] out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_normround dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_grs     (in_grs),
    .in_nshift  (in_nshift),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_inx    (out_inx)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [4:0]  nsh;
    logic        zero;
    logic [31:0] res;
    logic        ovf, unf, inx;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_grs    = v.grs;
    in_nshift = v.nsh;
    in_zero   = v.zero;
    in_valid  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge clk);
    drive(v);
    lat = 0;
    got = 0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1;
    end
    if (!got) lat = 99;
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    chk($sformatf("vec%0d_result", idx), out_result, v.res);
    chk($sformatf("vec%0d_flags", idx), {29'b0, out_ovf, out_unf, out_inx},
        {29'b0, v.ovf, v.unf, v.inx});
  endtask

  initial begin
    //           sign  exp     mant          grs     nsh   zero  result        ovf   unf   inx
    vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0,  1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd127, 25'h0000001, 3'b000, 5'd23, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd127, 25'h0800001, 3'b100, 5'd0,  1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'd127, 25'h0800000, 3'b100, 5'd0,  1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'd254, 25'h0FFFFFF, 3'b110, 5'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'd3,   25'h0000010, 3'b000, 5'd19, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 8'd127, 25'h0000000, 3'b000, 5'd0,  1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd254, 25'h1000000, 3'b000, 5'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'd127, 25'h1800001, 3'b000, 5'd0,  1'b0, 32'h40400000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'd127, 25'h1800003, 3'b000, 5'd0,  1'b0, 32'h40400002, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'd5,   25'h0040000, 3'b000, 5'd5,  1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'd6,   25'h0040000, 3'b000, 5'd5,  1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'd127, 25'h0800000, 3'b101, 5'd0,  1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'd127, 25'h0800000, 3'b011, 5'd0,  1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 5'd0,  1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'd255, 25'h0800000, 3'b000, 5'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 8'd127, 25'h0400000, 3'b100, 5'd1,  1'b0, 32'h3F000001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_grs = '0; in_nshift = '0; in_zero = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_flags", {29'b0, out_ovf, out_unf, out_inx}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Backpressure: four back-to-back items, downstream stalled for 3 cycles.
    begin
      int sent, rcv, c;
      logic [31:0] snap;
      sent = 0; rcv = 0; c = 0; snap = '0;
      @(negedge clk);
      while (rcv < 4 && c < 30) begin
        out_ready = (c >= 3);
        if (sent < 4) drive(vecs[sent]);
        else in_valid = 1'b0;
        #1;
        if (c == 2) begin
          chk("bp_accepts_before_stall", sent, 2);
          chk("bp_in_ready_stalled", {31'b0, in_ready}, 32'd0);
          chk("bp_out_valid_stalled", {31'b0, out_valid}, 32'd1);
          snap = out_result;
        end
        if (c == 3) chk("bp_result_held", out_result, snap);
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) begin
          chk($sformatf("bp_order%0d", rcv), out_result, vecs[rcv].res);
          rcv++;
        end
        c++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_all_received", rcv, 4);
    end

    // Reset while stalled with two items in flight.
    out_ready = 1'b0;
    @(negedge clk);
    drive(vecs[0]);
    @(negedge clk);
    drive(vecs[4]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_stall_out_valid_before", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_stall_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_stall_out_result", out_result, 32'd0);
    chk("rst_stall_flags", {29'b0, out_ovf, out_unf, out_inx}, 32'd0);
    chk("rst_stall_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rst_stall_discarded", seen, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
